inst_queue: RTL and testbench

Dual-slot instruction queue between the fetch stage and the dual-issue decode stage. It takes up to two fetched instructions per cycle, buffers them in a circular store, and presents the oldest two to decode. It honours the decode-stage stall and the front-end flush that the pipeline controller generates. It decouples I-cache fetch bandwidth from decode-side stalls and partial issue.

---
 rtl/inst_queue_if.sv | 26 ++
 rtl/inst_queue.sv | 102 ++++++++++
 tb/tb_inst_queue.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side signal bundle for the dual-slot instruction queue.
// The master side is the pipeline (fetch + decode). The queue itself uses the slave side.
interface inst_queue_if;
  // Handshake semantics:
  // - Fetch: a slot is accepted at an edge only when in_valid marks it and in_ready was high in that cycle.
  //   Otherwise fetch holds the slot.
  // - Decode: issue_cnt names how many of the out_valid slots are consumed at the edge.
  logic [1:0]       in_valid;
  logic [1:0][63:0] in_pc;
  logic [1:0][31:0] in_instr;
  logic             in_ready;
  logic [1:0]       issue_cnt;
  logic [1:0]       out_valid;
  logic [1:0][63:0] out_pc;
  logic [1:0][31:0] out_instr;

  modport master (
    output in_valid, in_pc, in_instr, issue_cnt,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, issue_cnt,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/inst_queue.sv
// Dual-slot circular instruction queue between fetch and dual-issue decode.
// It accepts up to two pushes and two pops per cycle, and flush clears the pointers.
module inst_queue #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall_id,
  inst_queue_if.slave   q,
  output logic [AW:0]   count
);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;
  logic [1:0]    issue_eff;

  logic [63:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  // in_ready looks only at registered count, so fetch never sees a path from decode.
  assign q.in_ready = (count <= (AW+1)'(DEPTH - 2));

  always_comb begin
    n_push = 2'd0;
    if (!flush && q.in_ready) begin
      case (q.in_valid)
        2'b01:   n_push = 2'd1;
        2'b11:   n_push = 2'd2;
        default: n_push = 2'd0;
      endcase
    end
  end

  always_comb begin
    issue_eff = (q.issue_cnt == 2'd3) ? 2'd2 : q.issue_cnt;
    n_pop     = 2'd0;
    if (!flush && !stall_id) begin
      if (count == '0)
        n_pop = 2'd0;
      else if (count == (AW+1)'(1))
        n_pop = (issue_eff != 2'd0) ? 2'd1 : 2'd0;
      else
        n_pop = issue_eff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count + (AW+1)'(n_push) - (AW+1)'(n_pop);
    end
  end

  // The storage array is not reset, because out_valid gates every read.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) begin
      pc_mem[tail]    <= q.in_pc[0];
      instr_mem[tail] <= q.in_instr[0];
    end
    if (n_push == 2'd2) begin
      pc_mem[tail_p1]    <= q.in_pc[1];
      instr_mem[tail_p1] <= q.in_instr[1];
    end
  end

  always_comb begin
    q.out_valid    = 2'b00;
    q.out_pc[0]    = 64'd0;
    q.out_pc[1]    = 64'd0;
    q.out_instr[0] = 32'd0;
    q.out_instr[1] = 32'd0;
    if (count >= (AW+1)'(1)) begin
      q.out_valid[0] = 1'b1;
      q.out_pc[0]    = pc_mem[head];
      q.out_instr[0] = instr_mem[head];
    end
    if (count >= (AW+1)'(2)) begin
      q.out_valid[1] = 1'b1;
      q.out_pc[1]    = pc_mem[head_p1];
      q.out_instr[1] = instr_mem[head_p1];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/full, wrap with partial issue,
// stall, flush priority and protocol edge cases.
module tb_inst_queue;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          flush;
  logic          stall_id;
  logic [AW:0]   count;
  int            n_checks;
  int            n_fail;
  logic [63:0]   exp_q[$];

  inst_queue_if iq();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_id (stall_id),
    .q        (iq.slave),
    .count    (count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return ~pc[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    iq.in_valid  = 2'b00;
    iq.in_pc[0]  = 64'd0;
    iq.in_pc[1]  = 64'd0;
    iq.in_instr[0] = 32'd0;
    iq.in_instr[1] = 32'd0;
    iq.issue_cnt = 2'd0;
    stall_id     = 1'b0;
    flush        = 1'b0;
  endtask

  // One cycle: drive inputs, take the edge, and return 1ns after it with the inputs idle.
  task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [1:0] ic, input logic st, input logic fl);
    iq.in_valid    = v;
    iq.in_pc[0]    = p0;
    iq.in_pc[1]    = p1;
    iq.in_instr[0] = instr_of(p0);
    iq.in_instr[1] = instr_of(p1);
    iq.issue_cnt   = ic;
    stall_id       = st;
    flush          = fl;
    @(posedge clk);
    #1;
    idle();
  endtask

  localparam logic [63:0] PA = 64'hFFFF_0000_0000_1000;
  localparam logic [63:0] PB = 64'hFFFF_0000_0000_1004;
  localparam logic [63:0] PC = 64'hFFFF_0000_0000_1008;
  localparam logic [63:0] PD = 64'hFFFF_0000_0000_100C;
  localparam logic [63:0] PE = 64'hFFFF_0000_0000_1010;
  localparam logic [63:0] PF = 64'h0000_1234_0000_2000;
  localparam logic [63:0] PG = 64'h0000_1234_0000_2004;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b0;
    #12;
    check("por_count", 64'(count), 64'd0);
    check("por_valid", 64'(iq.out_valid), 64'd0);
    check("por_ready", 64'(iq.in_ready), 64'd1);
    check("por_pc0", iq.out_pc[0], 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset mid-stream with 5 entries
    drive(2'b11, 64'h100, 64'h104, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 64'h108, 64'h10C, 2'd0, 1'b0, 1'b0);
    drive(2'b01, 64'h110, 64'h0,   2'd0, 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd5);
    check("pre_rst_pc0", iq.out_pc[0], 64'h100);
    #2;
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(iq.out_valid), 64'd0);
    check("rst_ready", 64'(iq.in_ready), 64'd1);
    check("rst_pc0", iq.out_pc[0], 64'd0);
    check("rst_instr1", 64'(iq.out_instr[1]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(2'b11, 64'h8000_0000, 64'h8000_0004, 2'd0, 1'b0, 1'b0);
    check("post_rst_valid", 64'(iq.out_valid), 64'd3);
    check("post_rst_pc0", iq.out_pc[0], 64'h8000_0000);
    check("post_rst_pc1", iq.out_pc[1], 64'h8000_0004);
    check("post_rst_instr0", 64'(iq.out_instr[0]), 64'h7FFF_FFFF);
    check("post_rst_instr1", 64'(iq.out_instr[1]), 64'h7FFF_FFFB);
    check("post_rst_count", 64'(count), 64'd2);

    // flush back to empty, then fill to full
    drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b0, 1'b1);
    check("flush0_count", 64'(count), 64'd0);
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, 64'h4000 + 64'(8*i), 64'h4004 + 64'(8*i), 2'd0, 1'b0, 1'b0);
      exp_q.push_back(64'h4000 + 64'(8*i));
      exp_q.push_back(64'h4004 + 64'(8*i));
    end
    check("fill14_count", 64'(count), 64'd14);
    check("fill14_ready", 64'(iq.in_ready), 64'd1);
    drive(2'b11, 64'h5000, 64'h5004, 2'd0, 1'b0, 1'b0);
    exp_q.push_back(64'h5000);
    exp_q.push_back(64'h5004);
    check("full_count", 64'(count), 64'd16);
    check("full_ready", 64'(iq.in_ready), 64'd0);
    drive(2'b11, 64'hDEAD_0000, 64'hDEAD_0004, 2'd0, 1'b0, 1'b0);
    check("full_hold_count", 64'(count), 64'd16);
    for (int i = 0; i < 8; i++) begin
      check("drain_pc0", iq.out_pc[0], exp_q[0]);
      check("drain_pc1", iq.out_pc[1], exp_q[1]);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0, 1'b0);
    end
    check("drained_count", 64'(count), 64'd0);

    // walk head to 13, tail to 15, count 2, then push A,B across the wrap
    drive(2'b01, 64'h200, 64'h0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      drive(2'b11, 64'h204 + 64'(8*i), 64'h208 + 64'(8*i), 2'd2, 1'b0, 1'b0);
    check("walk_count", 64'(count), 64'd2);
    drive(2'b11, PA, PB, 2'd2, 1'b0, 1'b0);
    drive(2'b01, PC, 64'h0, 2'd0, 1'b0, 1'b0);
    check("wrap_count3", 64'(count), 64'd3);
    check("wrap_pc0_a", iq.out_pc[0], PA);
    check("wrap_pc1_b", iq.out_pc[1], PB);
    check("wrap_instr1_b", 64'(iq.out_instr[1]), 64'(instr_of(PB)));
    drive(2'b11, PD, PE, 2'd1, 1'b0, 1'b0);
    check("partial_count", 64'(count), 64'd4);
    check("partial_pc0_b", iq.out_pc[0], PB);
    check("partial_pc1_c", iq.out_pc[1], PC);
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0, 1'b0);
    check("order_pc0_d", iq.out_pc[0], PD);
    check("order_pc1_e", iq.out_pc[1], PE);
    check("order_count", 64'(count), 64'd2);

    // stall with 4 entries
    drive(2'b11, PF, PG, 2'd0, 1'b0, 1'b0);
    check("stall_pre_count", 64'(count), 64'd4);
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b1, 1'b0);
    check("stall1_count", 64'(count), 64'd4);
    check("stall1_pc0", iq.out_pc[0], PD);
    check("stall1_pc1", iq.out_pc[1], PE);
    drive(2'b11, 64'h300, 64'h304, 2'd2, 1'b1, 1'b0);
    check("stall2_count", 64'(count), 64'd6);
    check("stall2_pc0", iq.out_pc[0], PD);
    drive(2'b11, 64'h308, 64'h30C, 2'd2, 1'b1, 1'b0);
    check("stall3_count", 64'(count), 64'd8);
    check("stall3_pc1", iq.out_pc[1], PE);

    // flush beats push, pop and stall with 6 entries
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0, 1'b0);
    check("preflush_count", 64'(count), 64'd6);
    check("preflush_pc0", iq.out_pc[0], PF);
    drive(2'b11, 64'h900, 64'h904, 2'd2, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(iq.out_valid), 64'd0);
    check("flush_pc0", iq.out_pc[0], 64'd0);
    check("flush_ready", 64'(iq.in_ready), 64'd1);
    drive(2'b01, 64'hA00, 64'h0, 2'd0, 1'b0, 1'b0);
    check("postflush_valid", 64'(iq.out_valid), 64'd1);
    check("postflush_pc0", iq.out_pc[0], 64'hA00);
    check("postflush_pc1", iq.out_pc[1], 64'd0);
    check("postflush_instr1", 64'(iq.out_instr[1]), 64'd0);

    // protocol edges
    drive(2'b10, 64'hB00, 64'hB04, 2'd0, 1'b0, 1'b0);
    check("v10_count", 64'(count), 64'd1);
    check("v10_valid", 64'(iq.out_valid), 64'd1);
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0, 1'b0);
    check("single_pop_count", 64'(count), 64'd0);
    check("single_pop_valid", 64'(iq.out_valid), 64'd0);
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0, 1'b0);
    check("empty_pop_count", 64'(count), 64'd0);
    drive(2'b01, 64'hC00, 64'h0, 2'd0, 1'b0, 1'b0);
    check("empty_pop_head", iq.out_pc[0], 64'hC00);
    drive(2'b11, 64'hC04, 64'hC08, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 64'hC0C, 64'hC10, 2'd0, 1'b0, 1'b0);
    check("five_count", 64'(count), 64'd5);
    drive(2'b00, 64'h0, 64'h0, 2'd3, 1'b0, 1'b0);
    check("issue3_count", 64'(count), 64'd3);
    check("issue3_pc0", iq.out_pc[0], 64'hC08);
    check("issue3_pc1", iq.out_pc[1], 64'hC0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
